irq_timer: RTL and testbench

Memory-mapped interval timer that produces the `IRQ` request consumed by the CPU control decoder. It sits on the data-memory bus beside data RAM, at base 0x4000_0000, and is driven by the same `MemRead`/`MemWrite` strobes.
- Software loads a reload value, enables the timer, and takes an interrupt on each counter overflow.
- The handler acknowledges the interrupt by clearing the status bit.
- A free-running cycle counter is also provided for software timing.

---
 rtl/irq_timer.sv | 106 ++++++++++
 tb/tb_irq_timer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_timer.sv
// Memory-mapped interval timer: TH reload, TL counter, TCON control/status, free-running SYSTICK; drives irq = IE & ST.
// Reads are combinational (0 cycles); writes land on the next rising edge; bus is never stalled.
module irq_timer #(
    parameter int          PRESCALE = 1,
    parameter logic [31:0] BASE     = 32'h4000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    localparam logic [15:0] PS_MAX = 16'(PRESCALE - 1);

    logic [31:0] th_q, th_d;
    logic [31:0] tl_q, tl_d;
    logic [31:0] systick_q, systick_d;
    logic [15:0] pcnt_q, pcnt_d;
    logic        en_q, en_d;
    logic        ie_q, ie_d;
    logic        st_q, st_d;

    logic hit;
    logic wr_th, wr_tl, wr_tcon;
    logic tick, ovf;
    logic unused_ok;

    assign unused_ok = &{1'b0, addr[1:0]};

    assign hit     = (addr[31:4] == BASE[31:4]);
    assign wr_th   = wr && hit && (addr[3:2] == 2'd0);
    assign wr_tl   = wr && hit && (addr[3:2] == 2'd1);
    assign wr_tcon = wr && hit && (addr[3:2] == 2'd2);

    // Tick and overflow are judged on pre-write state so a same-cycle TCON write cannot cancel them.
    assign tick = en_q && (pcnt_q == PS_MAX);
    assign ovf  = tick && (tl_q == 32'hFFFF_FFFF);

    always_comb begin
        th_d      = wr_th ? wdata : th_q;
        tl_d      = tl_q;
        en_d      = en_q;
        ie_d      = ie_q;
        st_d      = st_q;
        systick_d = systick_q + 32'd1;

        if (wr_tl) begin
            tl_d = wdata;
        end else if (ovf) begin
            tl_d = th_q;
        end else if (tick) begin
            tl_d = tl_q + 32'd1;
        end

        if (wr_tcon) begin
            en_d = wdata[0];
            ie_d = wdata[1];
            st_d = wdata[2];
        end
        // An overflow under the new IE overrides a software clear, so no interrupt is lost.
        if (ovf && ie_d) begin
            st_d = 1'b1;
        end

        pcnt_d = (!en_q || !en_d || tick) ? 16'd0 : pcnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            th_q      <= '0;
            tl_q      <= '0;
            systick_q <= '0;
            pcnt_q    <= '0;
            en_q      <= 1'b0;
            ie_q      <= 1'b0;
            st_q      <= 1'b0;
        end else begin
            th_q      <= th_d;
            tl_q      <= tl_d;
            systick_q <= systick_d;
            pcnt_q    <= pcnt_d;
            en_q      <= en_d;
            ie_q      <= ie_d;
            st_q      <= st_d;
        end
    end

    always_comb begin
        rdata = '0;
        if (rd && hit) begin
            case (addr[3:2])
                2'd0:    rdata = th_q;
                2'd1:    rdata = tl_q;
                2'd2:    rdata = {29'd0, st_q, ie_q, en_q};
                default: rdata = systick_q;
            endcase
        end
    end

    assign irq = ie_q && st_q;

endmodule

// File: tb/tb_irq_timer.sv
// Bench for irq_timer: two instances (PRESCALE 1 and 4) share one bus; fixed vectors, corner sequences, random traffic vs a reference model.
module tb_irq_timer;

    localparam logic [31:0] BASE  = 32'h4000_0000;
    localparam logic [31:0] A_TH  = BASE + 32'h0;
    localparam logic [31:0] A_TL  = BASE + 32'h4;
    localparam logic [31:0] A_TC  = BASE + 32'h8;
    localparam logic [31:0] A_SYS = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata1, rdata4;
    logic        irq1, irq4;

    irq_timer #(.PRESCALE(1), .BASE(BASE)) dut1 (
        .clk(clk), .reset(reset), .addr(addr), .rd(rd), .wr(wr),
        .wdata(wdata), .rdata(rdata1), .irq(irq1));
    irq_timer #(.PRESCALE(4), .BASE(BASE)) dut4 (
        .clk(clk), .reset(reset), .addr(addr), .rd(rd), .wr(wr),
        .wdata(wdata), .rdata(rdata4), .irq(irq4));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one entry per instance; index 0 has prescale 1, index 1 prescale 4.
    logic [31:0] m_th[2], m_tl[2], m_sys[2];
    bit          m_en[2], m_ie[2], m_st[2];
    int          m_ph[2];

    function automatic int ps(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            bit hit, tick, wrap, n_en, n_ie, n_st;
            if (reset) begin
                m_th[i] = 0; m_tl[i] = 0; m_sys[i] = 0;
                m_en[i] = 0; m_ie[i] = 0; m_st[i] = 0; m_ph[i] = 0;
            end else begin
                hit  = (addr[31:4] == BASE[31:4]);
                tick = m_en[i] && (m_ph[i] == ps(i) - 1);
                wrap = tick && (m_tl[i] == 32'hFFFF_FFFF);
                n_en = m_en[i]; n_ie = m_ie[i]; n_st = m_st[i];
                if (wr && hit && addr[3:2] == 2'd2) begin
                    n_en = wdata[0]; n_ie = wdata[1]; n_st = wdata[2];
                end
                if (wrap && n_ie) n_st = 1;
                if (wr && hit && addr[3:2] == 2'd1) m_tl[i] = wdata;
                else if (wrap)                      m_tl[i] = m_th[i];
                else if (tick)                      m_tl[i] = m_tl[i] + 1;
                if (wr && hit && addr[3:2] == 2'd0) m_th[i] = wdata;
                m_ph[i] = (tick || !n_en || !m_en[i]) ? 0 : m_ph[i] + 1;
                m_en[i] = n_en; m_ie[i] = n_ie; m_st[i] = n_st;
                m_sys[i] = m_sys[i] + 1;
            end
        end
    endtask

    function automatic logic [31:0] exp_rd(input int i);
        if (!rd || addr[31:4] != BASE[31:4]) return 32'd0;
        case (addr[3:2])
            2'd0:    return m_th[i];
            2'd1:    return m_tl[i];
            2'd2:    return {29'd0, m_st[i], m_ie[i], m_en[i]};
            default: return m_sys[i];
        endcase
    endfunction

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            chk("model_rdata_p1", rdata1, exp_rd(0));
            chk("model_rdata_p4", rdata4, exp_rd(1));
            chk("model_irq_p1", {31'd0, irq1}, {31'd0, m_ie[0] & m_st[0]});
            chk("model_irq_p4", {31'd0, irq4}, {31'd0, m_ie[1] & m_st[1]});
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_wr(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; wr = 1'b1;
        @(posedge clk);
        #1;
        wr = 1'b0;
    endtask

    task automatic rd_now(input logic [31:0] a, output logic [31:0] r1, output logic [31:0] r4);
        addr = a; rd = 1'b1;
        #1;
        r1 = rdata1; r4 = rdata4;
        rd = 1'b0;
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp;
        logic        exp_irq;
        string       nm;
    } vec_t;

    vec_t        tbl[15];
    logic [31:0] r1, r4, s1, s4, t1, t4;

    initial begin
        tbl[0]  = '{1'b0, A_TH,               32'h0,         32'h0,         1'b0, "th_reset"};
        tbl[1]  = '{1'b1, A_TH,               32'hA5A5_A5A5, 32'h0,         1'b0, "wr_th"};
        tbl[2]  = '{1'b0, A_TH,               32'h0,         32'hA5A5_A5A5, 1'b0, "rd_th"};
        tbl[3]  = '{1'b1, A_TL,               32'h1234_5678, 32'h0,         1'b0, "wr_tl"};
        tbl[4]  = '{1'b0, A_TL,               32'h0,         32'h1234_5678, 1'b0, "rd_tl"};
        tbl[5]  = '{1'b0, BASE + 32'h5,       32'h0,         32'h1234_5678, 1'b0, "rd_tl_lowbits"};
        tbl[6]  = '{1'b1, BASE + 32'h10,      32'h0,         32'h0,         1'b0, "wr_outside"};
        tbl[7]  = '{1'b0, A_TH,               32'h0,         32'hA5A5_A5A5, 1'b0, "th_not_aliased"};
        tbl[8]  = '{1'b0, BASE + 32'h10,      32'h0,         32'h0,         1'b0, "rd_outside"};
        tbl[9]  = '{1'b1, A_TC,               32'hFFFF_FFFE, 32'h0,         1'b1, "wr_tcon_6"};
        tbl[10] = '{1'b0, A_TC,               32'h0,         32'h6,         1'b1, "rd_tcon_6"};
        tbl[11] = '{1'b1, A_TC,               32'h4,         32'h0,         1'b0, "wr_tcon_4"};
        tbl[12] = '{1'b0, A_TC,               32'h0,         32'h4,         1'b0, "rd_tcon_4"};
        tbl[13] = '{1'b0, 32'h0000_0008,      32'h0,         32'h0,         1'b0, "rd_wrong_base"};
        tbl[14] = '{1'b1, A_TC,               32'h0,         32'h0,         1'b0, "wr_tcon_0"};

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk_on = 1'b1;
        chk("irq_after_reset", {30'd0, irq4, irq1}, 32'd0);

        for (int i = 0; i < 15; i++) begin
            if (tbl[i].we) begin
                do_wr(tbl[i].a, tbl[i].d);
            end else begin
                rd_now(tbl[i].a, r1, r4);
                chk({tbl[i].nm, "_p1"}, r1, tbl[i].exp);
                chk({tbl[i].nm, "_p4"}, r4, tbl[i].exp);
            end
            chk({tbl[i].nm, "_irq"}, {31'd0, irq1}, {31'd0, tbl[i].exp_irq});
        end
        addr = A_TH;
        #1;
        chk("no_rd_zero", rdata1, 32'd0);

        // Reset from a busy, interrupting state.
        do_wr(A_TH, 32'h1111_1111);
        do_wr(A_TL, 32'h2222_2222);
        do_wr(A_TC, 32'h7);
        cyc(3);
        chk("irq_preload", {31'd0, irq1}, 32'd1);
        reset_pulse();
        chk("irq_cleared", {30'd0, irq4, irq1}, 32'd0);
        rd_now(A_TH, r1, r4);  chk("rst_th", r1, 32'd0);
        rd_now(A_TL, r1, r4);  chk("rst_tl", r1, 32'd0);
        rd_now(A_TC, r1, r4);  chk("rst_tcon", r1, 32'd0);
        rd_now(A_SYS, r1, r4); chk("rst_systick", r1, 32'd0);

        // PRESCALE 1: 4-cycle overflow period.
        do_wr(A_TH, 32'hFFFF_FFFC);
        do_wr(A_TL, 32'hFFFF_FFFC);
        do_wr(A_TC, 32'h3);
        for (int k = 1; k <= 3; k++) begin
            cyc(1);
            chk("p1_irq_before_ovf", {31'd0, irq1}, 32'd0);
        end
        rd_now(A_TL, r1, r4);  chk("p1_tl_ffffffff", r1, 32'hFFFF_FFFF);
        cyc(1);
        chk("p1_irq_at_4", {31'd0, irq1}, 32'd1);
        rd_now(A_TL, r1, r4);  chk("p1_tl_reloaded", r1, 32'hFFFF_FFFC);

        do_wr(A_TC, 32'h3);
        chk("p1_irq_cleared", {31'd0, irq1}, 32'd0);
        cyc(2);
        chk("p1_irq_still_low", {31'd0, irq1}, 32'd0);
        cyc(1);
        chk("p1_irq_again", {31'd0, irq1}, 32'd1);

        cyc(3);
        do_wr(A_TC, 32'h3);
        chk("p1_clear_on_ovf_keeps_st", {31'd0, irq1}, 32'd1);
        rd_now(A_TL, r1, r4);  chk("p1_tl_reload2", r1, 32'hFFFF_FFFC);

        cyc(3);
        do_wr(A_TH, 32'h0000_0010);
        rd_now(A_TL, r1, r4);  chk("p1_reload_old_th", r1, 32'hFFFF_FFFC);
        rd_now(A_TH, r1, r4);  chk("p1_th_new", r1, 32'h0000_0010);

        // PRESCALE 4: overflow after 8 cycles, then a TL write on a tick.
        reset_pulse();
        do_wr(A_TH, 32'hFFFF_FFFE);
        do_wr(A_TL, 32'hFFFF_FFFE);
        do_wr(A_TC, 32'h3);
        cyc(7);
        chk("p4_irq_before", {31'd0, irq4}, 32'd0);
        cyc(1);
        chk("p4_irq_at_8", {31'd0, irq4}, 32'd1);
        rd_now(A_TL, r1, r4);  chk("p4_tl_reloaded", r4, 32'hFFFF_FFFE);
        cyc(3);
        do_wr(A_TL, 32'd5);
        rd_now(A_TL, r1, r4);  chk("p4_tl_write_wins", r4, 32'd5);
        cyc(3);
        rd_now(A_TL, r1, r4);  chk("p4_tl_hold", r4, 32'd5);
        cyc(1);
        rd_now(A_TL, r1, r4);  chk("p4_tl_incr", r4, 32'd6);

        reset_pulse();
        do_wr(A_TH, 32'hFFFF_FFFE);
        do_wr(A_TL, 32'hFFFF_FFFE);
        do_wr(A_TC, 32'h1);
        cyc(8);
        chk("p4_ie0_no_irq", {31'd0, irq4}, 32'd0);
        rd_now(A_TL, r1, r4);  chk("p4_ie0_reload", r4, 32'hFFFF_FFFE);
        rd_now(A_TC, r1, r4);  chk("p4_ie0_tcon", r4, 32'h1);

        // SYSTICK timing and write protection; simultaneous rd+wr.
        rd_now(A_SYS, s1, s4);
        cyc(10);
        rd_now(A_SYS, t1, t4);
        chk("systick_delta_p1", t1 - s1, 32'd10);
        chk("systick_delta_p4", t4 - s4, 32'd10);
        rd_now(A_SYS, s1, s4);
        do_wr(A_SYS, 32'd0);
        rd_now(A_SYS, t1, t4);
        chk("systick_wr_ignored", t1, s1 + 32'd1);

        addr = A_TH; wdata = 32'h0000_1234; wr = 1'b1; rd = 1'b1;
        #1;
        chk("rdwr_pre_value", rdata4, 32'hFFFF_FFFE);
        @(posedge clk);
        #1;
        wr = 1'b0;
        chk("rdwr_post_value", rdata4, 32'h0000_1234);
        rd = 1'b0;

        // Random traffic against the model.
        for (int n = 0; n < 800; n++) begin
            int sel;
            sel = $urandom_range(0, 4);
            addr = (sel == 4) ? BASE + 32'h10 : BASE + 32'(sel * 4);
            rd = 1'($urandom_range(0, 1));
            wr = ($urandom_range(0, 9) < 3);
            case (sel)
                2:       wdata = 32'($urandom_range(0, 7)) | (($urandom_range(0, 3) != 0) ? 32'h1 : 32'h0);
                default: wdata = ($urandom_range(0, 7) == 0) ? $urandom : (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)));
            endcase
            reset = ($urandom_range(0, 299) == 0);
            @(posedge clk);
            #1;
        end
        rd = 1'b0; wr = 1'b0; reset = 1'b0;
        cyc(2);
        chk_on = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
